// File: rtl/rca_digit_seq.sv
// Digit-serial sequencer around an external 2-bit ripple-carry slice.
// Walks operand pairs through the slice two bits per cycle and checks each slice result.
module rca_digit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_ci,
    input  logic [2:0]       slice_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy,
    output logic             cmp_err
);

    localparam int ND   = WIDTH / 2;
    localparam int IDXW = (ND > 1) ? $clog2(ND) : 1;
    localparam int SHW  = $clog2(WIDTH) + 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic [SHW-1:0]   base;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       ref_s;

    assign base = SHW'({idx_q, 1'b0});
    assign a_sh = a_q >> base;
    assign b_sh = b_q >> base;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_co    = 1'b0;
        slice_a   = 2'b00;
        slice_b   = 2'b00;
        slice_ci  = 1'b0;
        ref_s     = 3'b000;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                slice_a  = a_sh[1:0];
                slice_b  = b_sh[1:0];
                slice_ci = carry_q;
                ref_s    = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_ci};
                // Captured data always comes from the slice, never from the reference.
                sum_d    = (sum_q & ~(WIDTH'(3) << base))
                         | (WIDTH'(slice_s[1:0]) << base);
                carry_d  = slice_s[2];
                err_d    = err_q | (slice_s != ref_s);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_q;
                out_co    = carry_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign cmp_err = err_q;

endmodule

// File: tb/tb_rca_digit_seq.sv
// Bench for rca_digit_seq: behavioural slice, arithmetic reference,
// directed and randomized adds with immediate-assertion checks.
module tb_rca_digit_seq;

    localparam int W  = 8;
    localparam int ND = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ci = 1'b0;
    logic [1:0]   slice_a, slice_b;
    logic         slice_ci;
    logic [2:0]   slice_s;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         busy;
    logic         cmp_err;

    int tests = 0;
    int fails = 0;
    bit fault = 1'b0;
    bit exp_err = 1'b0;
    int dig = 0;

    rca_digit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
        .slice_s(slice_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co),
        .busy(busy), .cmp_err(cmp_err)
    );

    always #5 clk = ~clk;

    // Digit counter used only to place the injected slice fault.
    always @(posedge clk) dig <= busy ? dig + 1 : 0;

    logic [2:0] flip;
    assign flip = (fault && busy && dig == 2) ? 3'b001 : 3'b000;
    assign slice_s = busy
        ? ((3'(slice_a) + 3'(slice_b) + 3'(slice_ci)) ^ flip)
        : 3'bxxx;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // One add; hold = cycles with out_ready low once the result shows.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int hold);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic [31:0]  lo_sum, cin;
        wait_ready();
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        exp_sum = fault ? (full[W-1:0] ^ W'(8'h10)) : full[W-1:0];
        in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = W'($urandom);
        for (int d = 0; d < ND; d++) begin
            lo_sum = (32'(a) % (32'd1 << (2 * d))) + (32'(b) % (32'd1 << (2 * d)))
                   + 32'(ci);
            cin = lo_sum >> (2 * d);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("slice_a", 32'(slice_a), (32'(a) >> (2 * d)) & 32'd3);
            chk("slice_b", 32'(slice_b), (32'(b) >> (2 * d)) & 32'd3);
            chk("slice_ci", 32'(slice_ci), cin);
            chk("run_cmp_err", 32'(cmp_err), 32'(exp_err));
            step();
            if (fault && d == 2) exp_err = 1'b1;
        end
        chk("done_valid", 32'(out_valid), 32'd1);
        chk("done_sum", 32'(out_sum), 32'(exp_sum));
        chk("done_co", 32'(out_co), 32'(full[W]));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                step();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(out_sum), 32'(exp_sum));
                chk("hold_co", 32'(out_co), 32'(full[W]));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_cmp_err", 32'(cmp_err), 32'(exp_err));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_out_co"}, 32'(out_co), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cmp_err"}, 32'(cmp_err), 32'd0);
        chk({tag, "_slice"}, 32'({slice_a, slice_b, slice_ci}), 32'd0);
    endtask

    initial begin
        logic [W:0] expq[$];
        logic [W:0] e;
        logic [W-1:0] rb;
        int last_out;

        #3;
        chk_reset_outputs("rst");
        step();
        rst_n = 1'b1;
        step();
        chk_reset_outputs("post_rst");

        do_add(8'hFF, 8'h01, 1'b0, 0);
        do_add(8'hA5, 8'h5A, 1'b1, 0);
        do_add(8'h12, 8'h34, 1'b0, 6);
        do_add(8'hFF, 8'hFF, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            do_add(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));

        fault = 1'b1;
        do_add(W'($urandom), W'($urandom), 1'($urandom), 0);
        fault = 1'b0;
        do_add(8'h3C, 8'hC3, 1'b0, 1);
        do_add(W'($urandom), W'($urandom), 1'($urandom), 0);

        // Abort an add in its second cycle with an asynchronous reset.
        wait_ready();
        in_a = 8'h55; in_b = 8'h66; in_ci = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk_reset_outputs("mid_rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_stale_valid", 32'(out_valid), 32'd0);
        end
        do_add(8'h03, 8'h04, 1'b0, 0);

        // in_valid held high with operand A changing every cycle.
        rb = W'($urandom);
        in_b = rb; in_ci = 1'b0; in_valid = 1'b1;
        last_out = -1;
        for (int i = 0; i < 40; i++) begin
            in_a = W'($urandom);
            if (in_ready) expq.push_back({1'b0, in_a} + {1'b0, rb});
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                chk("stream_sum", 32'({out_co, out_sum}), 32'(e));
                if (last_out >= 0) chk("stream_gap", 32'(i - last_out), 32'd6);
                last_out = i;
            end
            step();
        end
        in_valid = 1'b0;
        chk("stream_seen", 32'(last_out > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rca_digit_seq.md
Name: rca_digit_seq

Overview:
- Digit-serial sequencer that drives the 2-bit ripple-carry adder slice (`rca4`-style: 2-bit a/b, carry-in, 3-bit s where s[2] is carry-out) and consumes its result.
- Accepts WIDTH-bit operand pairs over a valid/ready handshake and walks them through the slice two bits per cycle, chaining carry in a register.
- Assembles the WIDTH-bit sum plus carry-out and presents it downstream over valid/ready.
- Also checks every slice result against an internal reference add and flags mismatches.

Parameters:
- WIDTH, 8, operand/sum width; must be even and >= 2; digits processed = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair available.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  initial carry-in.
- slice_a  output  2  A digit driven to adder slice.
- slice_b  output  2  B digit driven to adder slice.
- slice_ci  output  1  carry driven to adder slice.
- slice_s  input  3  slice result; [1:0] sum digit, [2] carry-out; combinational from slice_* in same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  assembled sum.
- out_co  output  1  final carry-out.
- busy  output  1  high in RUN.
- cmp_err  output  1  sticky: some slice_s differed from slice_a+slice_b+slice_ci.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, digit index=0, operand/sum/carry registers=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_co=0, busy=0, cmp_err=0, slice_* = 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch in_a, in_b; carry<=in_ci; idx<=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - slice_a=a_reg[2*idx+1:2*idx], slice_b=b_reg[2*idx+1:2*idx], slice_ci=carry.
  - Each edge: sum_reg[2*idx+1:2*idx]<=slice_s[1:0]; carry<=slice_s[2]; idx<=idx+1.
  - When the digit with idx==WIDTH/2-1 is captured: go to DONE, idx wraps to 0.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_co=carry.
  - Outputs held stable until out_valid&&out_ready at an edge, then go to IDLE.
  - in_ready=0 in DONE; no back-to-back overlap.
- Latency:
  - Operand accepted at edge 0.
  - RUN occupies cycles 1..WIDTH/2.
  - out_valid first high in cycle WIDTH/2+1 (WIDTH=8: cycle 5).
  - Minimum 1 cycle in DONE and 1 in IDLE between transactions → throughput one add per WIDTH/2+2 cycles.
- Slice drive outside RUN: slice_a, slice_b, slice_ci = 0. Slice results are ignored outside RUN.
- Comparison:
  - In RUN each edge, compute ref = {1'b0,slice_a}+{1'b0,slice_b}+slice_ci (3-bit).
  - If slice_s != ref, set cmp_err<=1. cmp_err is cleared only by reset.
  - Captured data always comes from slice_s, never from ref.
- Wrap/overflow:
  - The full sum is the WIDTH-bit result plus out_co; no truncation of carry.
  - All-ones + all-ones + 1 gives out_sum = all-ones, out_co=1.
- in_valid while not in IDLE: ignored; the operand is not consumed because in_ready=0.
- out_ready while not in DONE: ignored.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and no out_valid follows.
- X on slice_s outside RUN must not propagate to any register.

Test Plan:
- WIDTH=8, in_a=8'hFF, in_b=8'h01, in_ci=0, out_ready=1, correct slice model:
  - out_valid rises in cycle 5 with out_sum=8'h00, out_co=1.
  - slice_ci sequence seen across RUN is 0,1,1,1.
- in_a=8'hA5, in_b=8'h5A, in_ci=1: out_sum=8'h00, out_co=1; cmp_err stays 0.
- Backpressure: in_a=8'h12, in_b=8'h34, in_ci=0, out_ready low for 6 cycles:
  - out_valid held with out_sum=8'h46, out_co=0 stable.
  - in_ready=0 throughout; IDLE is reached one cycle after out_ready=1.
- Faulty slice model that inverts s[0] on the digit-2 cycle:
  - cmp_err rises after that edge and stays 1 through later transactions until rst_n low.
- Reset mid-RUN:
  - Pull rst_n low during cycle 2 of an add: all outputs return to reset values asynchronously.
  - After release, a new add of 8'h03+8'h04 yields out_sum=8'h07, out_co=0.
- in_valid held high continuously with changing in_a:
  - Only the value present at the IDLE accept edge is used.
  - Successive results are spaced 6 cycles apart (WIDTH=8).
